// File: rtl/wb_unit_pkg.sv
// Shared opcode/funct constants and the pending-write entry layout for the
// write-back stage and the hazard unit.
package wb_unit_pkg;

  localparam int REGFILE_SIZE = 32;
  localparam int RF_ADR_W     = $clog2(REGFILE_SIZE);

  localparam logic [5:0] R_FORM = 6'h00;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BGTZ   = 6'h07;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] XORI   = 6'h0E;
  localparam logic [5:0] SW     = 6'h2B;

  localparam logic [5:0] JR     = 6'h08;

  typedef struct packed {
    logic [RF_ADR_W-1:0] adr;
    logic [31:0]         data;
    logic                valid;
  } wb_entry_t;

endpackage

// File: rtl/wb_dest_decode.sv
// Instruction word to {write-enable, destination register}; shared with the
// hazard unit, so $0 filtering is left to the consumer.
module wb_dest_decode
  import wb_unit_pkg::*;
(
  input  logic [31:0]         ins,
  output logic                we,
  output logic [RF_ADR_W-1:0] adr
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_ins;

  assign op = ins[31:26];
  assign fn = ins[5:0];

  always_comb begin
    we  = ((op > BGTZ) || (op == JAL) || ((op == R_FORM) && (fn != JR))) && (op != SW);
    adr = ins[20:16];
    if (op == R_FORM)
      adr = ins[15:11];
    else if (op == JAL)
      adr = 5'd31;
  end

  assign unused_ins = ^{ins[25:21], ins[10:6]};

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: buffers decoded register writes in a FIFO and drains one
// per cycle; bypass search over pending entries is built only with WB_BYPASS_EN.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_ins,
  input  logic [31:0]           in_result,
  input  logic [31:0]           in_pc4,
  input  logic                  rf_hold,
  output logic                  wr_en,
  output logic [4:0]            wr_adr,
  output logic [31:0]           wr_data,
  input  logic [4:0]            byp_adr1,
  input  logic [4:0]            byp_adr2,
  output logic                  byp_hit1,
  output logic                  byp_hit2,
  output logic [31:0]           byp_data1,
  output logic [31:0]           byp_data2,
  output logic [$clog2(DEPTH):0] count,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t            mem [DEPTH];
  wb_entry_t            head;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     cnt;
  logic                 dec_we;
  logic [RF_ADR_W-1:0]  dec_adr;
  logic [31:0]          push_data;
  logic                 xfer;
  logic                 push;
  logic                 pop;

  wb_dest_decode u_dec (
    .ins (in_ins),
    .we  (dec_we),
    .adr (dec_adr)
  );

  assign head      = mem[rd_ptr];
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign pop       = !empty && head.valid && !rf_hold;
  // Gate with RST so nothing is accepted while reset is held
  assign in_ready  = RST && ((cnt < CNT_W'(DEPTH)) || pop);
  assign xfer      = in_valid && in_ready;
  assign push      = xfer && dec_we && (dec_adr != '0);
  assign push_data = (in_ins[31:26] == JAL) ? in_pc4 : in_result;

  assign wr_en   = pop;
  assign wr_adr  = head.adr;
  assign wr_data = head.data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (pop) begin
        mem[rd_ptr].valid <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      // Full push+pop reuses the popped slot; this write must win
      if (push) begin
        mem[wr_ptr] <= '{adr: dec_adr, data: push_data, valid: 1'b1};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so the last match is the youngest
  always_comb begin
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = '0;
    byp_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[rd_ptr + PTR_W'(i)].valid && (byp_adr1 != '0) &&
          (mem[rd_ptr + PTR_W'(i)].adr == byp_adr1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = mem[rd_ptr + PTR_W'(i)].data;
      end
      if (mem[rd_ptr + PTR_W'(i)].valid && (byp_adr2 != '0) &&
          (mem[rd_ptr + PTR_W'(i)].adr == byp_adr2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = mem[rd_ptr + PTR_W'(i)].data;
      end
    end
  end
`else
  logic unused_byp;

  assign byp_hit1   = 1'b0;
  assign byp_hit2   = 1'b0;
  assign byp_data1  = '0;
  assign byp_data2  = '0;
  assign unused_byp = ^{byp_adr1, byp_adr2};
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboarded bench for wb_unit: expected writes are queued on acceptance
// and a negedge monitor compares every register-file write against them.
module tb_wb_unit;
  import wb_unit_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_ins = '0;
  logic [31:0] in_result = '0;
  logic [31:0] in_pc4 = '0;
  logic        rf_hold = 1'b0;
  logic        wr_en;
  logic [4:0]  wr_adr;
  logic [31:0] wr_data;
  logic [4:0]  byp_adr1 = '0;
  logic [4:0]  byp_adr2 = '0;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [31:0] byp_data1;
  logic [31:0] byp_data2;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q [$];

  wb_unit #(.DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .in_result(in_result), .in_pc4(in_pc4),
    .rf_hold(rf_hold),
    .wr_en(wr_en), .wr_adr(wr_adr), .wr_data(wr_data),
    .byp_adr1(byp_adr1), .byp_adr2(byp_adr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
    .count(count), .empty(empty)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] i_form(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd0, rt, 16'h0000};
  endfunction

  function automatic logic [31:0] r_form(input logic [4:0] rs, input logic [4:0] rd, input logic [5:0] fn);
    return {R_FORM, rs, 5'd0, rd, 5'd0, fn};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Call just after a posedge; returns 1ns after the accepting edge.
  task automatic push(input logic [31:0] ins, input logic [31:0] res, input logic [31:0] pc4,
                      input bit wr, input logic [4:0] ea, input logic [31:0] ed);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_ins    = ins;
    in_result = res;
    in_pc4    = pc4;
    @(negedge CLK);
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stayed 0 for ins 0x%0h", ins);
    end else if (wr) begin
      exp_q.push_back({ea, ed});
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got adr=%0d data=0x%0h expected no write", wr_adr, wr_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({wr_adr, wr_data} !== e) begin
          errors++;
          $display("FAIL write_order: got adr=%0d data=0x%0h expected adr=%0d data=0x%0h",
                   wr_adr, wr_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    byp_adr1 = 5'd5;
    repeat (2) @(negedge CLK);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_byp_hit1", 32'(byp_hit1), 0);
    @(posedge CLK);
    #1 RST = 1'b1;
    tick();

    // Drain order and one-cycle latency
    push(i_form(ADDI, 5'd5), 32'h1234, 32'h9990, 1, 5'd5, 32'h1234);
    chk("lat_first_wr_en", 32'(wr_en), 1);
    chk("lat_first_adr", 32'(wr_adr), 5);
    push(r_form(5'd2, 5'd7, 6'h20), 32'hA5, 32'h9994, 1, 5'd7, 32'hA5);
    chk("lat_second_adr", 32'(wr_adr), 7);
    repeat (2) @(negedge CLK);
    chk("drain_count", 32'(count), 0);
    chk("drain_empty", 32'(empty), 1);

    // JAL link value and non-writers
    tick();
    push({JAL, 26'h0000100}, 32'hDEAD, 32'h400, 1, 5'd31, 32'h400);
    repeat (2) @(negedge CLK);
    tick();
    push({SW, 5'd0, 5'd5, 16'h0}, 32'h77, 32'h0, 0, 5'd0, 32'h0);
    chk("sw_count", 32'(count), 0);
    push(r_form(5'd31, 5'd3, JR), 32'h78, 32'h0, 0, 5'd0, 32'h0);
    chk("jr_count", 32'(count), 0);
    push(i_form(ADDI, 5'd0), 32'h79, 32'h0, 0, 5'd0, 32'h0);
    chk("r0_count", 32'(count), 0);
    push(32'h1006_0000, 32'h7A, 32'h0, 0, 5'd0, 32'h0);
    chk("beq_empty", 32'(empty), 1);

    // Full with hold, then push+pop while full
    rf_hold = 1'b1;
    for (int k = 1; k <= 4; k++)
      push(i_form(ADDI, 5'(k)), 32'h100 + 32'(k), 32'h0, 1, 5'(k), 32'h100 + 32'(k));
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_hold_wr_en", 32'(wr_en), 0);
    fork
      push(i_form(XORI, 5'd6), 32'h106, 32'h0, 1, 5'd6, 32'h106);
      begin
        repeat (3) @(posedge CLK);
        #1 rf_hold = 1'b0;
      end
    join
    chk("full_pushpop_count", 32'(count), 4);
    repeat (6) @(negedge CLK);
    chk("full_drained", 32'(empty), 1);

    // Bypass priority: youngest wins, popping entry still visible
    tick();
    rf_hold = 1'b1;
    push(i_form(ADDI, 5'd9), 32'h11, 32'h0, 1, 5'd9, 32'h11);
    push(i_form(ADDI, 5'd9), 32'h22, 32'h0, 1, 5'd9, 32'h22);
    byp_adr1 = 5'd9;
    byp_adr2 = 5'd0;
    #1;
    chk("byp_hit1", 32'(byp_hit1), 32'(BYP));
    chk("byp_data1_youngest", byp_data1, BYP ? 32'h22 : 32'h0);
    chk("byp_adr0_hit2", 32'(byp_hit2), 0);
    chk("byp_adr0_data2", byp_data2, 0);
    byp_adr2 = 5'd4;
    #1 chk("byp_miss_hit2", 32'(byp_hit2), 0);
    rf_hold = 1'b0;
    #1;
    chk("byp_popping_hit1", 32'(byp_hit1), 32'(BYP));
    chk("byp_popping_data1", byp_data1, BYP ? 32'h22 : 32'h0);
    tick();
    chk("byp_after_pop1_hit", 32'(byp_hit1), 32'(BYP));
    chk("byp_after_pop1_data", byp_data1, BYP ? 32'h22 : 32'h0);
    tick();
    chk("byp_after_pop2_hit", 32'(byp_hit1), 0);

    // Asynchronous reset with writes pending
    tick();
    rf_hold = 1'b1;
    push(i_form(ADDI, 5'd11), 32'h211, 32'h0, 1, 5'd11, 32'h211);
    push(i_form(ADDI, 5'd12), 32'h212, 32'h0, 1, 5'd12, 32'h212);
    push(i_form(ADDI, 5'd13), 32'h213, 32'h0, 1, 5'd13, 32'h213);
    chk("pre_rst_count", 32'(count), 3);
    byp_adr1 = 5'd12;
    #1 chk("pre_rst_byp_hit1", 32'(byp_hit1), 32'(BYP));
    @(negedge CLK);
    #2 rf_hold = 1'b0;
    #1 chk("pre_rst_wr_en", 32'(wr_en), 1);
    RST = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_wr_en", 32'(wr_en), 0);
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_byp_hit1", 32'(byp_hit1), 0);
    chk("async_rst_in_ready", 32'(in_ready), 0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    repeat (6) @(negedge CLK);
    chk("post_rst_empty", 32'(empty), 1);

    tick();
    push(i_form(XORI, 5'd10), 32'h55, 32'h0, 1, 5'd10, 32'h55);
    repeat (3) @(negedge CLK);
    chk("final_empty", 32'(empty), 1);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Write-back stage for the MIPS pipeline; the writer side of the register-file write port that the decode stage reads.
- Accepts completed instructions with their results over a valid/ready handshake.
- Decodes destination register and write-enable from the instruction, buffers pending writes in a small FIFO, and drains one write per cycle into the register file.
- Exposes a two-port bypass lookup so decode can read not-yet-committed values.

Parameters:
- DEPTH, 4, number of pending-write entries; power of two, >= 2.
- REGFILE_SIZE, 32, register count; address width is 5.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-low
- in_valid  in  1  producer has a completed instruction
- in_ready  out  1  unit can accept this cycle
- in_ins  in  32  instruction word
- in_result  in  32  ALU/load result
- in_pc4  in  32  PC+4 of the instruction, used as the JAL link value
- rf_hold  in  1  register file not accepting a write this cycle
- wr_en  out  1  register-file write strobe
- wr_adr  out  5  write address
- wr_data  out  32  write data
- byp_adr1, byp_adr2  in  5 each  decode read addresses
- byp_hit1, byp_hit2  out  1 each  a pending entry matches
- byp_data1, byp_data2  out  32 each  youngest matching pending data
- count  out  clog2(DEPTH)+1  pending entries
- empty  out  1  count==0

Behaviour:
- Reset (RST low, async): pointers=0, count=0, all entries invalid.
  - While in reset: wr_en=0, empty=1, byp_hit*=0, in_ready=0.
  - A write in flight at the reset edge is lost; nothing drains during reset.
- Decode, from op=in_ins[31:26] and fn=in_ins[5:0]:
  - Writes when (op > BGTZ) or op==JAL or (op==R_FORM and fn!=JR), and op!=SW.
  - Destination: rd=in_ins[15:11] if R_FORM; 31 if JAL; else rt=in_ins[20:16].
  - Data: in_pc4 if JAL, else in_result.
  - Writes to register 0 are dropped.
- Handshake:
  - Transfer when in_valid && in_ready.
  - in_ready = (count<DEPTH) || pop. Simultaneous push+pop when full is legal.
  - Non-writing or $0-destination instructions complete the transfer but allocate no entry.
- Drain: pop = !empty && !rf_hold.
  - wr_en=pop; wr_adr/wr_data come from the head entry, combinationally.
  - While rf_hold=1, head is held stable; wr_en=0.
- Latency: an entry accepted at edge N is first offered on wr_* in cycle N+1. There is no fall-through from input to wr_*.
- FIFO:
  - Pointers wrap modulo DEPTH.
  - count += push − pop; push and pop in the same cycle leaves count unchanged.
  - Order is strictly preserved.
- Bypass:
  - Search all valid entries and select the youngest match.
  - Address 0 never hits.
  - The entry being popped this cycle still counts as a hit; the register file holds it only after the edge.
  - An input in the same cycle is not visible until accepted.
- Ordering: two pending writes to the same register both drain, in order; the last one wins.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: bypass search logic as described above.
- Undefined: byp_hit*=0, byp_data*=0, no search logic.
  - In this build decode must stall until empty=1 on any hazard.
  - Handshake and drain behaviour are identical in both builds.

Decomposition:
- Shared package/header common_param.vh:
  - Opcode constants: R_FORM, JAL, BGTZ, SW, ADDI, XORI.
  - Funct constant: JR.
  - REGFILE_SIZE.
  - Entry struct: adr[4:0], data[31:0], valid.
- One sub-module, wb_dest_decode: purely combinational mapping of instruction word to {we, adr}. It is shared with the hazard unit.

Test Plan:
- Reset and drain order: release RST, push ADDI rt=5 result 0x1234 then R-form rd=7 result 0xA5.
  - Expect wr_en at cycles 1 and 2: (5,0x1234) then (7,0xA5).
  - count returns to 0 and empty=1.
- JAL and non-writers: push JAL with in_pc4=0x400 → write (31,0x400).
  - Push SW, JR, and ADDI rt=0: each is accepted (in_ready=1), count stays 0, wr_en never asserts.
- Full with hold: rf_hold=1, push 4 writes.
  - Expect count=4, in_ready=0.
  - A 5th in_valid stalls until rf_hold drops. Then the push+pop cycle keeps count=4 and all 5 writes drain in order.
- Bypass priority: hold, push r9=0x11 then r9=0x22.
  - byp_adr1=9 → hit=1, data=0x22.
  - byp_adr2=0 → hit=0.
  - Release hold: after the first pop, data is still 0x22; after the second pop, hit=0.
- Async reset mid-operation: with 3 entries pending, pull RST low between edges.
  - wr_en, count and byp_hit* go to 0 immediately.
  - After release, no stale writes occur.
- WB_BYPASS_EN undefined: repeat the bypass scenario; byp_hit*=0 throughout while drain behaviour is unchanged.
